// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle.
// The master side (board / bench) drives the raw buttons and vsync.
// The slave side (the conditioner) drives the cleaned levels and the fire pulse.
interface button_conditioner_if;
  logic left_in;
  logic right_in;
  logic fire_in;
  logic vsync_in;
  logic left_out;
  logic right_out;
  logic fire_pulse;
  logic fire_ready;

  modport master (
    output left_in,
    output right_in,
    output fire_in,
    output vsync_in,
    input  left_out,
    input  right_out,
    input  fire_pulse,
    input  fire_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  fire_in,
    input  vsync_in,
    output left_out,
    output right_out,
    output fire_pulse,
    output fire_ready
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the left/right/missile buttons.
// Left/right leave as clean direction levels; a simultaneous press of both
// cancels out. Missile becomes a one-cycle fire pulse that is rate limited by
// a cooldown counted in frames (vsync rising edges).
//
// Optional feature macro: BUTTON_AUTOFIRE_EN
//   defined   -> holding fire shoots again each time the cooldown expires
//   undefined -> one shot per press; a new rising edge is needed in READY
//
// Latency of a clean, held level change: DEBOUNCE_CYCLES+3 pclk edges
// (2 synchroniser + DEBOUNCE_CYCLES count + 1 output register).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                  pclk,
  input  logic                  rst,
  button_conditioner_if.slave   btn
);

  // Counter widths; both are kept at least one bit wide for tiny parameters.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  // Button lane indices
  localparam int NB    = 3;
  localparam int IDX_L = 0;
  localparam int IDX_R = 1;
  localparam int IDX_F = 2;

  typedef enum logic {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  logic [NB-1:0] raw_in;
  logic [NB-1:0] stable_w;

  assign raw_in = {btn.fire_in, btn.right_in, btn.left_in};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_btn
      logic            s1_q;
      logic            s2_q;
      logic            stable_q;
      logic            stable_d;
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          stable_d = s2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Two-flop synchroniser followed by the debounce state
      always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= raw_in[gi];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable_w[gi] = stable_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Direction outputs: pressing both directions at once cancels out
  // ---------------------------------------------------------------------------
  logic left_q;
  logic right_q;
  logic left_d;
  logic right_d;

  // Mutually exclusive direction levels
  always_comb begin
    left_d  = stable_w[IDX_L] & ~stable_w[IDX_R];
    right_d = stable_w[IDX_R] & ~stable_w[IDX_L];
  end

  // Registered direction outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection for the fire button and for vsync
  // ---------------------------------------------------------------------------
  logic fire_dly_q;
  logic vsync_dly_q;
  logic fire_rise;
  logic vsync_rise;
  logic fire_cond;

  // One-cycle delayed copies used for rising-edge detection
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      fire_dly_q  <= 1'b0;
      vsync_dly_q <= 1'b0;
    end else begin
      fire_dly_q  <= stable_w[IDX_F];
      vsync_dly_q <= btn.vsync_in;
    end
  end

  assign fire_rise  = stable_w[IDX_F] & ~fire_dly_q;
  assign vsync_rise = btn.vsync_in & ~vsync_dly_q;

`ifdef BUTTON_AUTOFIRE_EN
  // A fresh edge implies the level, so this is simply the held fire level.
  assign fire_cond = stable_w[IDX_F] | fire_rise;
`else
  // Only a new press seen while READY may shoot; a held button shoots once.
  assign fire_cond = fire_rise;
`endif

  // ---------------------------------------------------------------------------
  // Fire FSM with frame-counted cooldown
  // ---------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [CD_W-1:0] cd_q;
  logic [CD_W-1:0] cd_d;
  logic            fire_pulse_q;
  logic            fire_pulse_d;
  logic            fire_ready_q;
  logic            fire_ready_d;

  // Next state: shoot from READY, count frames down in COOLDOWN
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    fire_pulse_d = 1'b0;
    case (state_q)
      ST_READY: begin
        // A vsync edge coinciding with the shot is ignored: the load wins.
        if (fire_cond) begin
          fire_pulse_d = 1'b1;
          cd_d         = CD_LOAD;
          state_d      = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        // Presses here are dropped; counter never wraps below zero.
        if (cd_q == '0) begin
          state_d = ST_READY;
        end else if (vsync_rise) begin
          cd_d = cd_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
    fire_ready_d = (state_d == ST_READY);
  end

  // FSM state, cooldown counter and registered fire outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_READY;
      cd_q         <= '0;
      fire_pulse_q <= 1'b0;
      fire_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      fire_pulse_q <= fire_pulse_d;
      fire_ready_q <= fire_ready_d;
    end
  end

  assign btn.left_out   = left_q;
  assign btn.right_out  = right_q;
  assign btn.fire_pulse = fire_pulse_q;
  assign btn.fire_ready = fire_ready_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2,
// vsync pulse every 20 cycles). Expected output vectors
// {left_out, right_out, fire_pulse, fire_ready} are queued per cycle when
// stimulus is driven, and compared at the falling edge of that cycle.
module tb_button_conditioner;
  localparam int DB        = 4;
  localparam int CF        = 2;
  localparam int VS_PERIOD = 20;
  localparam int VS_PHASE  = 10;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_FRAMES(CF)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .btn (bus)
  );

  initial forever #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic expect_span(input string tag, input int a, input int b, input logic [3:0] v);
    exp_t e;
    for (int k = a; k <= b; k++) begin
      e.tag = tag;
      e.cyc = k;
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic drive(input string what, input logic l, input logic r, input logic f);
    bus.left_in  = l;
    bus.right_in = r;
    bus.fire_in  = f;
    $display("[cyc %0d] %s: left=%0b right=%0b fire=%0b", cyc, what, l, r, f);
  endtask

  // Cycle at which fire_ready is back to 1 after a shot landing at edge s
  function automatic int ready_at(input int s);
    int v;
    v = s;
    while (v % VS_PERIOD != VS_PHASE) v++;
    return v + VS_PERIOD * (CF - 1) + 2;
  endfunction

  // vsync: high for the single cycle whose count is VS_PHASE mod VS_PERIOD
  initial begin
    bus.vsync_in = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      bus.vsync_in = (cyc % VS_PERIOD == VS_PHASE);
    end
  end

  // Scoreboard compare of every queued vector due this cycle
  always @(negedge pclk) begin
    logic [3:0] obs;
    obs = {bus.left_out, bus.right_out, bus.fire_pulse, bus.fire_ready};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_eq($sformatf("%s@%0d", sb[i].tag, sb[i].cyc), {28'd0, obs}, {28'd0, sb[i].v});
        sb.delete(i);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int s;
    bus.left_in  = 1'b0;
    bus.right_in = 1'b0;
    bus.fire_in  = 1'b0;
    rst          = 1'b0;
    expect_span("reset", 1, 3, 4'b0001);
    goto(3);
    rst = 1'b1;
    $display("[cyc %0d] reset released", cyc);
    expect_span("idle", 4, 10, 4'b0001);

    // 1: 3-cycle glitch rejected, then held level appears after 7 edges
    goto(10);  drive("glitch_on", 1, 0, 0);
    expect_span("glitch", 11, 30, 4'b0001);
    goto(13);  drive("glitch_off", 0, 0, 0);
    goto(30);  drive("left_hold", 1, 0, 0);
    expect_span("left_lat", 31, 36, 4'b0001);
    expect_span("left_on", 37, 39, 4'b1001);

    // 2: both pressed cancel; releasing right gives left
    goto(40);  drive("left_rel", 0, 0, 0);
    expect_span("left_still", 40, 46, 4'b1001);
    expect_span("left_off", 47, 50, 4'b0001);
    goto(50);  drive("both", 1, 1, 0);
    expect_span("conflict", 51, 70, 4'b0001);
    goto(70);  drive("right_rel", 1, 0, 0);
    expect_span("conf_lat", 71, 76, 4'b0001);
    expect_span("conf_left", 77, 80, 4'b1001);
    goto(80);  drive("left_rel2", 0, 0, 0);
    expect_span("left_fall", 81, 86, 4'b1001);
    expect_span("left_idle", 87, 90, 4'b0001);
    goto(90);  drive("right_hold", 0, 1, 0);
    expect_span("right_lat", 91, 96, 4'b0001);
    expect_span("right_on", 97, 100, 4'b0101);
    goto(100); drive("right_rel2", 0, 0, 0);
    expect_span("right_fall", 101, 106, 4'b0101);
    expect_span("right_idle", 107, 110, 4'b0001);

`ifndef BUTTON_AUTOFIRE_EN
    // 3: single shot per press
    goto(110); drive("fire_hold", 0, 0, 1);
    expect_span("fire_lat", 111, 116, 4'b0001);
    expect_span("shot1", 117, 117, 4'b0010);
    r = ready_at(117);
    expect_span("cool1", 118, r - 1, 4'b0000);
    expect_span("held_noshot", r, 180, 4'b0001);
    goto(180); drive("fire_rel", 0, 0, 0);
    expect_span("rel_idle", 181, 204, 4'b0001);
    // second press lands with a vsync edge in the shot cycle: load wins
    goto(204); drive("fire_again", 0, 0, 1);
    expect_span("fire_lat2", 205, 210, 4'b0001);
    expect_span("shot2", 211, 211, 4'b0010);
    r = ready_at(211);
    expect_span("cool2", 212, r - 1, 4'b0000);
    expect_span("ready2", r, 260, 4'b0001);
    goto(260); drive("fire_rel2", 0, 0, 0);
    expect_span("rel_idle2", 261, 270, 4'b0001);
`else
    // 4: autofire, one pulse per cooldown period while held
    goto(110); drive("fire_hold", 0, 0, 1);
    expect_span("fire_lat", 111, 116, 4'b0001);
    s = 117;
    repeat (3) begin
      expect_span("auto_shot", s, s, 4'b0010);
      r = ready_at(s);
      expect_span("auto_cool", s + 1, r - 1, 4'b0000);
      expect_span("auto_ready", r, r, 4'b0001);
      s = r + 1;
    end
    goto(210); drive("fire_rel", 0, 0, 0);
    expect_span("rel_idle", s, 270, 4'b0001);
`endif

    // 5: press and release entirely inside cooldown is dropped
    goto(270); drive("fire_press", 0, 0, 1);
    expect_span("fire_lat3", 271, 276, 4'b0001);
    expect_span("shot3", 277, 277, 4'b0010);
    expect_span("cool3", 278, 280, 4'b0000);
    goto(280); drive("fire_rel3", 0, 0, 0);
    expect_span("cool3", 281, 290, 4'b0000);
    goto(290); drive("cool_press", 0, 0, 1);
    expect_span("drop", 291, 300, 4'b0000);
    goto(300); drive("cool_rel", 0, 0, 0);
    r = ready_at(277);
    expect_span("drop", 301, r - 1, 4'b0000);
    expect_span("no_late_shot", r, 325, 4'b0001);

    // 6: reset in cooldown, held buttons debounce again afterwards
    goto(325); drive("left_hold6", 1, 0, 0);
    expect_span("left_lat6", 326, 331, 4'b0001);
    expect_span("left_on6", 332, 336, 4'b1001);
    goto(330); drive("fire_hold6", 1, 0, 1);
    expect_span("shot6", 337, 337, 4'b1010);
    expect_span("cool6", 338, 344, 4'b1000);
    goto(345);
    rst = 1'b0;
    $display("[cyc %0d] reset asserted", cyc);
    expect_span("mid_reset", 345, 348, 4'b0001);
    goto(348);
    rst = 1'b1;
    $display("[cyc %0d] reset released", cyc);
    expect_span("post_lat", 349, 354, 4'b0001);
    expect_span("post_shot", 355, 355, 4'b1010);
    expect_span("post_cool", 356, 380, 4'b1000);
    goto(380); drive("all_rel", 0, 0, 0);
    r = ready_at(355);
    expect_span("post_cool", 381, 386, 4'b1000);
    expect_span("post_left_off", 387, r - 1, 4'b0000);
    expect_span("post_ready", r, 400, 4'b0001);

    goto(405);
    check_eq("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
